// File: rtl/encoder_debounce_pkg.sv
// Shared constants for the encoder input conditioning path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package encoder_debounce_pkg;

  // Default synchronizer depth and debounce window for the encoder contacts.
  localparam int ENC_SYNC_STAGES     = 2;
  localparam int ENC_DEBOUNCE_CYCLES = 255;

  // Diagnostic glitch counter width and its saturation value.
  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  // Stability counter width: max(1, clog2(cycles)).
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/encoder_debounce_if.sv
// Raw contact inputs and conditioned outputs of the encoder debouncer.
// Latency: n/a (wiring only).
// Backpressure: none; levels and strobes, no handshake.
interface encoder_debounce_if;
  import encoder_debounce_pkg::*;

  logic                a_raw;
  logic                b_raw;
  logic                a;
  logic                b;
  logic                a_edge;
  logic                b_edge;
  logic [GLITCH_W-1:0] glitch_count;

  // Pin side: drives the raw contacts, observes the conditioned outputs.
  modport master (
    output a_raw, b_raw,
    input  a, b, a_edge, b_edge, glitch_count
  );

  // Debouncer side.
  modport slave (
    input  a_raw, b_raw,
    output a, b, a_edge, b_edge, glitch_count
  );

endinterface

// File: rtl/encoder_debounce_channel.sv
// One contact channel: synchronizer, stability-count debouncer, change strobe, glitch event.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from the first sampling edge to a new level.
// Backpressure: none; glitch is a combinational event off registered state only.
module debounce_channel
  import encoder_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = ENC_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = ENC_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic out,
  output logic edge_pulse,
  output logic glitch
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt;

  // Plain shift chain; the raw contact is asynchronous, so nothing sits between stages.
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  assign s = sync[SYNC_STAGES-1];

  // Accept a new level only after it has disagreed with out for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= 1'b0;
      cnt        <= '0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= 1'b0;
      if (s == out) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        out        <= s;
        cnt        <= '0;
        edge_pulse <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // A pending transition that falls back to the current level before completing.
  assign glitch = (s == out) && (cnt != '0);

endmodule

// File: rtl/encoder_debounce.sv
// Conditions raw quadrature contacts A/B into clean levels, change strobes and a glitch count.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles per clean step; glitch_count one cycle after the event.
// Backpressure: none; outputs are free-running levels/strobes, glitch_count saturates.
module encoder_debounce
  import encoder_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = ENC_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = ENC_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  encoder_debounce_if.slave  bus
);

  localparam int SUM_W = GLITCH_W + 1;

  logic             glitch_a;
  logic             glitch_b;
  logic [SUM_W-1:0] glitch_sum;

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk        (clk),
    .reset      (reset),
    .raw        (bus.a_raw),
    .out        (bus.a),
    .edge_pulse (bus.a_edge),
    .glitch     (glitch_a)
  );

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk        (clk),
    .reset      (reset),
    .raw        (bus.b_raw),
    .out        (bus.b),
    .edge_pulse (bus.b_edge),
    .glitch     (glitch_b)
  );

  // One extra bit so a simultaneous +2 near the top is caught before clamping.
  always_comb begin
    glitch_sum = {1'b0, bus.glitch_count} + SUM_W'(glitch_a) + SUM_W'(glitch_b);
  end

  // Saturating accumulator of aborted transitions from both channels.
  always_ff @(posedge clk) begin
    if (reset)                   bus.glitch_count <= '0;
    else if (glitch_sum[GLITCH_W]) bus.glitch_count <= GLITCH_MAX;
    else                         bus.glitch_count <= glitch_sum[GLITCH_W-1:0];
  end

endmodule
